xgmii_loop_tester: RTL

Parametrised multi-channel XGMII64 frame generator and checker for 10GBASE-R loopback bring-up and regression. It generates numbered test frames on CH independent XGMII transmit channels and checks the frames returned on CH receive channels. It keeps per-channel frame and error counters. It sits between the `tr_baser_wrapper`/`simple10GbaseR` XGMII ports and the test or control logic, and replaces hand-driven XGMII stimulus in the top-level bench.

---
 rtl/xgmii_loop_tester.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_loop_tester.sv
// rtl/xgmii_loop_tester.sv - multi-channel XGMII64 loopback frame generator and checker
// Define XGMII_LOOP_TESTER_DRC_EN to flag illegal XGMII control codes in the checker.
module xgmii_loop_tester #(
   parameter int CH  = 1,
   parameter int LEN = 8,
   parameter int IFG = 2
) (
   input  logic              clk_156,
   input  logic              rst_156,
   input  logic [CH-1:0]     run,
   input  logic [CH-1:0]     clr,
   input  logic [CH-1:0]     tx_rdy,
   output logic [CH*64-1:0]  tx_data,
   output logic [CH*8-1:0]   tx_ctrl,
   output logic [CH-1:0]     tx_ena,
   input  logic [CH*64-1:0]  rx_data,
   input  logic [CH*8-1:0]   rx_ctrl,
   input  logic [CH-1:0]     rx_ena,
   output logic [CH*32-1:0]  tx_cnt,
   output logic [CH*32-1:0]  rx_cnt,
   output logic [CH*32-1:0]  err_cnt,
   output logic [CH-1:0]     err
);
   localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
   localparam logic [63:0] START_D = 64'hD5555555555555FB;
   localparam logic [63:0] TERM_D  = 64'h07070707070707FD;
   localparam logic [8:0]  LEN_W   = 9'(LEN);
   localparam logic [7:0]  LAST_K  = 8'(LEN - 1);
   localparam logic [3:0]  IFG_W   = 4'(IFG);

   typedef enum logic [1:0] {G_GAP, G_START, G_DATA, G_TERM} gen_state_t;
   typedef enum logic {C_HUNT, C_DATA} chk_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

`ifdef XGMII_LOOP_TESTER_DRC_EN
   function automatic logic drc_bad(input logic [63:0] d, input logic [7:0] c);
      logic b;
      b = 1'b0;
      for (int i = 0; i < 8; i++)
         if (c[i] && d[i*8+:8] != 8'h07 && d[i*8+:8] != 8'hFB && d[i*8+:8] != 8'hFD)
            b = 1'b1;
      return b;
   endfunction
`endif

   for (genvar c = 0; c < CH; c++) begin : g_ch
      gen_state_t  gst_q, gst_d;
      chk_state_t  cst_q, cst_d;
      logic [3:0]  gap_q, gap_d;
      logic [7:0]  gk_q, gk_d;
      logic [31:0] fnum_q, fnum_d;
      logic [63:0] txd_q, txd_d;
      logic [7:0]  txc_q, txc_d;
      logic        txe_q, txe_d;
      logic [8:0]  ck_q, ck_d;
      logic [31:0] expf_q, expf_d;
      logic        mism_q, mism_d;
      logic [31:0] txcnt_q, txcnt_d, rxcnt_q, rxcnt_d, errcnt_q, errcnt_d;
      logic        err_q, err_d;
      logic        sent, good, bad, herr;
      logic [63:0] rd;
      logic [7:0]  rc;
      logic        is_start, is_term, is_pay;

      assign rd       = rx_data[c*64+:64];
      assign rc       = rx_ctrl[c*8+:8];
      assign is_start = (rc == 8'h01) && (rd == START_D);
      assign is_term  = (rc == 8'hFF) && (rd == TERM_D);
      assign is_pay   = (rc == 8'h00);

      // Generator: the registered word only moves on once the PCS has taken it.
      always_comb begin
         gst_d  = gst_q;
         gap_d  = gap_q;
         gk_d   = gk_q;
         fnum_d = fnum_q;
         txd_d  = txd_q;
         txc_d  = txc_q;
         txe_d  = 1'b1;
         sent   = 1'b0;
         if (!txe_q) begin
            gst_d = G_GAP;
            gap_d = 4'd1;
            txd_d = IDLE_D;
            txc_d = 8'hFF;
         end else if (tx_rdy[c]) begin
            unique case (gst_q)
               G_GAP: begin
                  if (gap_q >= IFG_W && run[c]) begin
                     gst_d = G_START;
                     txd_d = START_D;
                     txc_d = 8'h01;
                  end else begin
                     txd_d = IDLE_D;
                     txc_d = 8'hFF;
                     if (gap_q != 4'hF) gap_d = gap_q + 4'd1;
                  end
               end
               G_START: begin
                  gst_d = G_DATA;
                  gk_d  = 8'd0;
                  txd_d = {fnum_q, 32'd0};
                  txc_d = 8'h00;
               end
               G_DATA: begin
                  if (gk_q == LAST_K) begin
                     gst_d = G_TERM;
                     txd_d = TERM_D;
                     txc_d = 8'hFF;
                  end else begin
                     gk_d  = gk_q + 8'd1;
                     txd_d = {fnum_q, 24'd0, gk_q + 8'd1};
                     txc_d = 8'h00;
                  end
               end
               G_TERM: begin
                  sent   = 1'b1;
                  fnum_d = fnum_q + 32'd1;
                  gst_d  = G_GAP;
                  gap_d  = 4'd1;
                  txd_d  = IDLE_D;
                  txc_d  = 8'hFF;
               end
            endcase
         end
      end

      // Checker: the frame number resyncs on word 0, so only intra-frame continuity is checked.
      always_comb begin
         cst_d  = cst_q;
         ck_d   = ck_q;
         expf_d = expf_q;
         mism_d = mism_q;
         good   = 1'b0;
         bad    = 1'b0;
         herr   = 1'b0;
         if (rx_ena[c]) begin
            if (cst_q == C_HUNT) begin
               if (is_start) begin
                  cst_d  = C_DATA;
                  ck_d   = 9'd0;
                  mism_d = 1'b0;
               end
`ifdef XGMII_LOOP_TESTER_DRC_EN
               else if (drc_bad(rd, rc)) herr = 1'b1;
`endif
            end else if (is_pay) begin
               if (ck_q == LEN_W) begin
                  bad   = 1'b1;
                  cst_d = C_HUNT;
               end else begin
                  if (ck_q == 9'd0) expf_d = rd[63:32];
                  else if (rd[63:32] != expf_q) mism_d = 1'b1;
                  if (rd[31:0] != {23'd0, ck_q}) mism_d = 1'b1;
                  ck_d = ck_q + 9'd1;
               end
            end else if (is_term) begin
               if (ck_q == LEN_W && !mism_q) good = 1'b1;
               else bad = 1'b1;
               cst_d = C_HUNT;
            end else begin
               bad   = 1'b1;
               cst_d = C_HUNT;
               if (is_start) begin
                  cst_d  = C_DATA;
                  ck_d   = 9'd0;
                  mism_d = 1'b0;
               end
            end
         end
      end

      always_comb begin
         txcnt_d  = sent ? sat_inc(txcnt_q) : txcnt_q;
         rxcnt_d  = good ? sat_inc(rxcnt_q) : rxcnt_q;
         errcnt_d = (bad || herr) ? sat_inc(errcnt_q) : errcnt_q;
         err_d    = err_q | bad | herr;
         if (clr[c]) begin
            txcnt_d  = 32'd0;
            rxcnt_d  = 32'd0;
            errcnt_d = 32'd0;
            err_d    = 1'b0;
         end
      end

      always_ff @(posedge clk_156) begin
         if (rst_156) begin
            gst_q    <= G_GAP;
            gap_q    <= 4'd0;
            gk_q     <= 8'd0;
            fnum_q   <= 32'd0;
            txd_q    <= IDLE_D;
            txc_q    <= 8'hFF;
            txe_q    <= 1'b0;
            cst_q    <= C_HUNT;
            ck_q     <= 9'd0;
            expf_q   <= 32'd0;
            mism_q   <= 1'b0;
            txcnt_q  <= 32'd0;
            rxcnt_q  <= 32'd0;
            errcnt_q <= 32'd0;
            err_q    <= 1'b0;
         end else begin
            gst_q    <= gst_d;
            gap_q    <= gap_d;
            gk_q     <= gk_d;
            fnum_q   <= fnum_d;
            txd_q    <= txd_d;
            txc_q    <= txc_d;
            txe_q    <= txe_d;
            cst_q    <= cst_d;
            ck_q     <= ck_d;
            expf_q   <= expf_d;
            mism_q   <= mism_d;
            txcnt_q  <= txcnt_d;
            rxcnt_q  <= rxcnt_d;
            errcnt_q <= errcnt_d;
            err_q    <= err_d;
         end
      end

      assign tx_data[c*64+:64] = txd_q;
      assign tx_ctrl[c*8+:8]   = txc_q;
      assign tx_ena[c]         = txe_q;
      assign tx_cnt[c*32+:32]  = txcnt_q;
      assign rx_cnt[c*32+:32]  = rxcnt_q;
      assign err_cnt[c*32+:32] = errcnt_q;
      assign err[c]            = err_q;
   end
endmodule
